rgb_fade_sequencer: RTL and testbench

- Controller that drives the shared RGB PWM LED datapath from a small programmed table instead of a free-running sawtooth.
- Holds 4 entries, each a red/green/blue target level plus a hold time.
- Ramps the three channel levels toward each entry's target one LSB per tick, holds, then advances to the next entry.
- Outputs `level_red/green/blue` feed three PWM instances directly; the table is written over a valid/ready config port while idle.

---
 rtl/rgb_fade_sequencer.sv | 175 +++++++++++++++++
 tb/tb_rgb_fade_sequencer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/rgb_fade_sequencer.sv
// Table-driven RGB fade controller: ramps three channel levels toward up to four programmed
// targets one LSB per tick, holds each for a programmed time, then advances or stops.
module rgb_fade_sequencer #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned HOLD_BITS = 8,
   parameter int unsigned PRESCALER = 0,
   parameter bit          LOOP      = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 cfg_valid,
   output logic                 cfg_ready,
   input  logic [1:0]           cfg_addr,
   input  logic [WIDTH-1:0]     cfg_red,
   input  logic [WIDTH-1:0]     cfg_green,
   input  logic [WIDTH-1:0]     cfg_blue,
   input  logic [HOLD_BITS-1:0] cfg_hold,
   input  logic                 cfg_last,
   input  logic                 start,
   input  logic                 stop,
   output logic                 busy,
   output logic [1:0]           step_index,
   output logic [WIDTH-1:0]     level_red,
   output logic [WIDTH-1:0]     level_green,
   output logic [WIDTH-1:0]     level_blue,
   output logic                 seq_done
);

   typedef enum logic [1:0] {StIdle, StFade, StHold} state_e;

   state_e               state_q, state_d;
   logic [1:0]           step_q, step_d;
   logic [1:0]           last_q;
   logic [WIDTH-1:0]     red_q, red_d, green_q, green_d, blue_q, blue_d;
   logic [HOLD_BITS-1:0] hold_q, hold_d;
   logic                 done_q, done_d;

   logic [WIDTH-1:0]     tbl_red   [4];
   logic [WIDTH-1:0]     tbl_green [4];
   logic [WIDTH-1:0]     tbl_blue  [4];
   logic [HOLD_BITS-1:0] tbl_hold  [4];

   logic tick;
   logic start_accept;
   logic wr_en;
   logic at_target;

   assign cfg_ready    = (state_q == StIdle);
   assign busy         = (state_q != StIdle);
   assign start_accept = (state_q == StIdle) && start && !stop;
   assign wr_en        = cfg_valid && cfg_ready;

   assign step_index  = step_q;
   assign level_red   = red_q;
   assign level_green = green_q;
   assign level_blue  = blue_q;
   assign seq_done    = done_q;

   // Counter restarts on start so the first step lands a fixed number of clocks later.
   if (PRESCALER == 0) begin : g_no_presc
      assign tick = 1'b1;
   end else begin : g_presc
      localparam logic [PRESCALER-1:0] PrescOne = 1;
      logic [PRESCALER-1:0] presc_q;
      always_ff @(posedge clk) begin
         if (rst || start_accept) presc_q <= '0;
         else                     presc_q <= presc_q + PrescOne;
      end
      assign tick = &presc_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) begin
            tbl_red[i]   <= '0;
            tbl_green[i] <= '0;
            tbl_blue[i]  <= '0;
            tbl_hold[i]  <= '0;
         end
         last_q <= 2'd3;
      end else if (wr_en) begin
         tbl_red[cfg_addr]   <= cfg_red;
         tbl_green[cfg_addr] <= cfg_green;
         tbl_blue[cfg_addr]  <= cfg_blue;
         tbl_hold[cfg_addr]  <= cfg_hold;
         if (cfg_last) last_q <= cfg_addr;
      end
   end

   function automatic logic [WIDTH-1:0] toward(input logic [WIDTH-1:0] cur,
                                                input logic [WIDTH-1:0] tgt);
      if (cur < tgt)      return cur + WIDTH'(1);
      else if (cur > tgt) return cur - WIDTH'(1);
      else                return cur;
   endfunction

   assign at_target = (red_q == tbl_red[step_q]) && (green_q == tbl_green[step_q]) &&
                      (blue_q == tbl_blue[step_q]);

   always_comb begin
      state_d = state_q;
      step_d  = step_q;
      red_d   = red_q;
      green_d = green_q;
      blue_d  = blue_q;
      hold_d  = hold_q;
      done_d  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start_accept) begin
               step_d  = 2'd0;
               state_d = StFade;
            end
         end
         StFade: begin
            if (at_target) begin
               state_d = StHold;
               hold_d  = tbl_hold[step_q];
            end else if (tick) begin
               red_d   = toward(red_q, tbl_red[step_q]);
               green_d = toward(green_q, tbl_green[step_q]);
               blue_d  = toward(blue_q, tbl_blue[step_q]);
            end
         end
         StHold: begin
            if (tick) begin
               if (hold_q != '0) begin
                  hold_d = hold_q - HOLD_BITS'(1);
               end else if (step_q != last_q) begin
                  step_d  = step_q + 2'd1;
                  state_d = StFade;
               end else if (LOOP) begin
                  step_d  = 2'd0;
                  state_d = StFade;
               end else begin
                  state_d = StIdle;
                  done_d  = 1'b1;
               end
            end
         end
         default: state_d = StIdle;
      endcase
      // Abort freezes everything except the state itself.
      if (stop) begin
         state_d = StIdle;
         step_d  = step_q;
         red_d   = red_q;
         green_d = green_q;
         blue_d  = blue_q;
         hold_d  = hold_q;
         done_d  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         step_q  <= 2'd0;
         red_q   <= '0;
         green_q <= '0;
         blue_q  <= '0;
         hold_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
         red_q   <= red_d;
         green_q <= green_d;
         blue_q  <= blue_d;
         hold_q  <= hold_d;
         done_q  <= done_d;
      end
   end

endmodule

// File: tb/tb_rgb_fade_sequencer.sv
// Directed bench for rgb_fade_sequencer: three instances share stimulus (plain, looping,
// prescaled) and each test checks the instance it targets.
module tb_rgb_fade_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic       cfg_valid;
   logic [1:0] cfg_addr;
   logic [7:0] cfg_red, cfg_green, cfg_blue, cfg_hold;
   logic       cfg_last, start, stop;

   logic       ready_a, busy_a, done_a;
   logic [1:0] step_a;
   logic [7:0] red_a, green_a, blue_a;
   logic       ready_l, busy_l, done_l;
   logic [1:0] step_l;
   logic [7:0] red_l, green_l, blue_l;
   logic       ready_p, busy_p, done_p;
   logic [1:0] step_p;
   logic [7:0] red_p, green_p, blue_p;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   rgb_fade_sequencer #(.WIDTH(8), .HOLD_BITS(8), .PRESCALER(0), .LOOP(1'b0)) dut_a (
      .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(ready_a), .cfg_addr(cfg_addr),
      .cfg_red(cfg_red), .cfg_green(cfg_green), .cfg_blue(cfg_blue), .cfg_hold(cfg_hold),
      .cfg_last(cfg_last), .start(start), .stop(stop), .busy(busy_a), .step_index(step_a),
      .level_red(red_a), .level_green(green_a), .level_blue(blue_a), .seq_done(done_a));

   rgb_fade_sequencer #(.WIDTH(8), .HOLD_BITS(8), .PRESCALER(0), .LOOP(1'b1)) dut_l (
      .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(ready_l), .cfg_addr(cfg_addr),
      .cfg_red(cfg_red), .cfg_green(cfg_green), .cfg_blue(cfg_blue), .cfg_hold(cfg_hold),
      .cfg_last(cfg_last), .start(start), .stop(stop), .busy(busy_l), .step_index(step_l),
      .level_red(red_l), .level_green(green_l), .level_blue(blue_l), .seq_done(done_l));

   rgb_fade_sequencer #(.WIDTH(8), .HOLD_BITS(8), .PRESCALER(2), .LOOP(1'b0)) dut_p (
      .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(ready_p), .cfg_addr(cfg_addr),
      .cfg_red(cfg_red), .cfg_green(cfg_green), .cfg_blue(cfg_blue), .cfg_hold(cfg_hold),
      .cfg_last(cfg_last), .start(start), .stop(stop), .busy(busy_p), .step_index(step_p),
      .level_red(red_p), .level_green(green_p), .level_blue(blue_p), .seq_done(done_p));

   typedef struct {
      logic       start;
      logic       busy;
      logic       ready;
      logic       done;
      logic [7:0] red;
   } vec_t;

   vec_t vecs[10];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   task automatic cfg_write(input logic [1:0] a, input logic [7:0] r, input logic [7:0] g,
                            input logic [7:0] b, input logic [7:0] h, input logic l);
      cfg_valid = 1'b1;
      cfg_addr  = a;
      cfg_red   = r;
      cfg_green = g;
      cfg_blue  = b;
      cfg_hold  = h;
      cfg_last  = l;
      step();
      cfg_valid = 1'b0;
      cfg_last  = 1'b0;
   endtask

   task automatic wait_idle_a();
      for (int k = 0; k < 200 && busy_a; k++) step();
      chk("wait_idle_a", busy_a, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got running, expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      int pulses;
      rst = 1'b1; cfg_valid = 1'b0; cfg_addr = '0; cfg_red = '0; cfg_green = '0;
      cfg_blue = '0; cfg_hold = '0; cfg_last = 1'b0; start = 1'b0; stop = 1'b0;

      // Single entry (3,0,0), hold 2, last 0, non-looping: cycle-by-cycle expectations.
      vecs[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'd0};
      vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
      vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'd1};
      vecs[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'd2};
      vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'd3};
      vecs[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'd3};
      vecs[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'd3};
      vecs[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'd3};
      vecs[8] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'd3};
      vecs[9] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'd3};

      step();
      do_reset();
      chk("reset_a", {ready_a, busy_a, done_a, step_a, red_a, green_a, blue_a},
          {1'b1, 1'b0, 1'b0, 2'd0, 24'd0});
      chk("reset_l", {ready_l, busy_l, done_l, step_l, red_l, green_l, blue_l},
          {1'b1, 1'b0, 1'b0, 2'd0, 24'd0});
      chk("reset_p", {ready_p, busy_p, done_p, step_p, red_p, green_p, blue_p},
          {1'b1, 1'b0, 1'b0, 2'd0, 24'd0});

      cfg_write(2'd0, 8'd3, 8'd0, 8'd0, 8'd2, 1'b1);
      for (int i = 0; i < 10; i++) begin
         chk($sformatf("single_busy[%0d]", i), busy_a, vecs[i].busy);
         chk($sformatf("single_ready[%0d]", i), ready_a, vecs[i].ready);
         chk($sformatf("single_done[%0d]", i), done_a, vecs[i].done);
         chk($sformatf("single_red[%0d]", i), red_a, vecs[i].red);
         start = vecs[i].start;
         step();
         start = 1'b0;
      end

      // Mixed directions: move to (5,0,2), then fade to (2,3,2).
      cfg_write(2'd0, 8'd5, 8'd0, 8'd2, 8'd0, 1'b1);
      start = 1'b1; step(); start = 1'b0;
      wait_idle_a();
      chk("mixed_pre", {red_a, green_a, blue_a}, {8'd5, 8'd0, 8'd2});
      cfg_write(2'd0, 8'd2, 8'd3, 8'd2, 8'd0, 1'b1);
      start = 1'b1; step(); start = 1'b0;
      step();
      chk("mixed_c2", {red_a, green_a, blue_a}, {8'd4, 8'd1, 8'd2});
      step();
      chk("mixed_c3", {red_a, green_a, blue_a}, {8'd3, 8'd2, 8'd2});
      step();
      chk("mixed_c4", {red_a, green_a, blue_a, busy_a}, {8'd2, 8'd3, 8'd2, 1'b1});
      step();
      chk("mixed_c5_hold", {busy_a, done_a}, {1'b1, 1'b0});
      step();
      chk("mixed_c6_done", {busy_a, done_a}, {1'b0, 1'b1});

      // Looping two-entry program.
      do_reset();
      cfg_write(2'd0, 8'd1, 8'd0, 8'd0, 8'd0, 1'b0);
      cfg_write(2'd1, 8'd0, 8'd1, 8'd0, 8'd0, 1'b1);
      start = 1'b1; step(); start = 1'b0;
      pulses = 0;
      for (int c = 1; c <= 20; c++) begin
         if (done_l) pulses++;
         if (c % 3 == 2) chk($sformatf("loop_step_c%0d", c), step_l, ((c - 2) / 3) % 2);
         if (c < 20) step();
      end
      chk("loop_no_done", pulses, 0);
      chk("loop_busy", busy_l, 1);

      // Prescaler of 2: steps every 4 clocks.
      do_reset();
      cfg_write(2'd0, 8'd2, 8'd0, 8'd0, 8'd0, 1'b1);
      start = 1'b1; step(); start = 1'b0;
      step(); step(); step();
      chk("presc_c4", red_p, 0);
      step();
      chk("presc_c5", red_p, 1);
      step(); step(); step();
      chk("presc_c8", red_p, 1);
      step();
      chk("presc_c9", red_p, 2);

      // Handshake: writes blocked while busy, accepted right after stop.
      do_reset();
      cfg_write(2'd0, 8'd4, 8'd0, 8'd0, 8'd3, 1'b1);
      start = 1'b1; step(); start = 1'b0;
      cfg_valid = 1'b1; cfg_addr = 2'd0; cfg_red = 8'd9; cfg_green = 8'd0; cfg_blue = 8'd0;
      cfg_hold = 8'd0; cfg_last = 1'b1;
      for (int c = 1; c <= 6; c++) begin
         chk($sformatf("hs_ready_c%0d", c), ready_a, 0);
         step();
      end
      chk("hs_c7_level", {busy_a, red_a}, {1'b1, 8'd4});
      stop = 1'b1; step(); stop = 1'b0;
      chk("hs_after_stop", {busy_a, ready_a, done_a, red_a}, {1'b0, 1'b1, 1'b0, 8'd4});
      step();
      cfg_valid = 1'b0; cfg_last = 1'b0;
      start = 1'b1; step(); start = 1'b0;
      chk("hs_restart_busy", busy_a, 1);
      step();
      chk("hs_new_target", red_a, 5);
      wait_idle_a();
      chk("hs_final_red", red_a, 9);

      // start and stop together stay idle.
      start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
      chk("start_stop_c1", {busy_a, ready_a}, {1'b0, 1'b1});
      step();
      chk("start_stop_c2", busy_a, 0);

      // Reset in the middle of HOLD.
      do_reset();
      cfg_write(2'd0, 8'd2, 8'd2, 8'd2, 8'd10, 1'b1);
      start = 1'b1; step(); start = 1'b0;
      for (int c = 1; c < 6; c++) step();
      chk("rst_pre_hold", {busy_a, red_a, green_a, blue_a}, {1'b1, 8'd2, 8'd2, 8'd2});
      do_reset();
      chk("rst_mid_hold", {busy_a, ready_a, step_a, red_a, green_a, blue_a},
          {1'b0, 1'b1, 2'd0, 24'd0});
      start = 1'b1; step(); start = 1'b0;
      for (int c = 1; c < 7; c++) step();
      chk("rst_last_idx3", {busy_a, step_a}, {1'b1, 2'd3});
      step(); step();
      chk("rst_fresh_done", {busy_a, done_a, red_a, green_a, blue_a},
          {1'b0, 1'b1, 24'd0});

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
